peripheral_bfm_slave_axi4: RTL and testbench
============================================

Name: peripheral_bfm_slave_axi4

Overview:
- Downstream AXI4 slave memory model that consumes the transactions issued by the peripheral BFM master in DMA/MPSoC benches.
- Accepts the write address, write data and read address channels; returns write responses and read data from an internal word-addressed memory.
- Supports FIXED, INCR and WRAP bursts of 1-16 beats.

Parameters:
- MEM_AW, 10, memory word-address width (depth = 2^MEM_AW 32-bit words)
- BASE_ADDR, 32'h0000_0000, byte base address of the memory window

Ports:
- aclk  input  1  clock
- areset  input  1  synchronous active-high reset
- awid  input  4  write address ID
- awadr  input  32  write byte address
- awlen  input  4  burst length minus 1
- awsize  input  3  bytes per beat = 2^awsize
- awburst  input  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wid  input  4  write ID (ignored; awid is authoritative)
- wrdata  input  32  write data
- wstrb  input  4  byte lanes
- wlast  input  1  last write beat
- wvalid  input  1  write valid
- wready  output  1  write ready
- bid  output  4  response ID (= latched awid)
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  response ready
- arid  input  4  read address ID
- araddr  input  32  read byte address
- arlen  input  4  burst length minus 1
- arsize  input  3  bytes per beat
- arburst  input  2  burst type
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rid  output  4  read ID (= latched arid)
- rdata  output  32  read data
- rresp  output  2  read response
- rlast  output  1  last read beat
- rvalid  output  1  read valid
- rready  input  1  read ready

Behaviour:
- Reset (areset=1 at posedge aclk): all outputs 0; both FSMs return to IDLE. Memory contents are not cleared. A reset mid-burst aborts the burst; beats already written persist. awready and arready rise on the first cycle after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/size/burst, clear the beat counter, go to W_DATA (awready=0, wready=1 next cycle).
  - W_DATA: each wvalid&wready writes the strobed bytes into mem[word index], then advances the address.
  - Last beat is beat count == len. Go to W_RESP: wready=0, bvalid=1 next cycle.
  - If wlast disagrees with the beat count on any beat, still terminate at beat len and set bresp=2'b10 (SLVERR). Otherwise bresp=2'b00.
  - W_RESP: hold bvalid/bid/bresp stable until bready, then W_IDLE.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch fields and go to R_DATA.
  - First rvalid appears exactly 1 cycle after the AR handshake (registered memory read).
  - R_DATA: rdata/rid/rresp/rlast are held stable while rvalid&!rready.
  - On rvalid&rready, advance the address and present the next word on the following cycle, giving 1 beat/cycle with rready held high.
  - rlast=1 only on beat len. After its handshake, rvalid=0 and go to R_IDLE.
  - rresp=2'b00 always, except under the optional feature.
- Address arithmetic (both channels):
  - Word index = ((addr - BASE_ADDR) >> 2) modulo 2^MEM_AW, so indices wrap at the memory end.
  - Size values > 2 are treated as 2.
  - FIXED: address is never incremented.
  - INCR: addr += 2^size.
  - WRAP: wraps within an aligned block of (len+1)*2^size bytes; len must be 1, 3, 7 or 15, and other lengths behave as INCR.
  - Narrow writes use wstrb as presented. Reads always return the full word.
- Channels are independent; a read and a write may proceed concurrently. If both hit the same word in the same cycle, the read returns the old data.
- Only one outstanding transaction per direction; no reordering.

Optional Feature:
- Macro PERIPHERAL_BFM_SLAVE_DECERR_EN.
- Defined:
  - Any beat whose byte address is outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_AW) is dropped for writes, and the burst's bresp=2'b11 (DECERR overrides SLVERR).
  - For reads, that beat returns rdata=0 with rresp=2'b11.
- Undefined: addresses alias modulo the memory depth, and DECERR is never generated.

Test Plan:
- Single write: AW id=3, addr 0x10, len 0, size 2, INCR; W 0xDEADBEEF, strb 4'hF, wlast=1 -> bvalid 1 cycle after the W handshake, bid=3, bresp=00. Then AR 0x10 -> rdata=0xDEADBEEF, rlast=1, rresp=00, rvalid 1 cycle after AR.
- INCR 4-beat write of 1,2,3,4 at 0x20, then INCR 4-beat read with rready toggling 1,0,1,0,... -> data 1,2,3,4 in order, held stable while stalled, rlast only on beat 4.
- WRAP len 3 write at 0x38 with data A,B,C,D -> words 0x38=A, 0x3C=B, 0x30=C, 0x34=D; an INCR read from 0x30 returns C,D,A,B.
- Byte strobes: write 0x11223344 strb 4'b0101 over 0xFFFFFFFF at 0x40 -> read 0xFF22FF44. FIXED len 3 write of 5,6,7,8 to 0x44 -> read 0x44 = 8.
- wlast asserted on beat 1 of a len=2 burst -> burst ends after beat 3, bresp=2'b10. Reset asserted mid-burst -> bvalid=0, awready=1 one cycle after release, and beats already written are retained.
- DECERR_EN defined, BASE_ADDR=0, MEM_AW=10: write to 0x1000 -> bresp=2'b11 and memory unchanged; read of 0x1000 -> rdata=0, rresp=2'b11. Macro undefined: the same write aliases to 0x0000.

Source files
------------

// File: rtl/peripheral_bfm_slave_axi4.sv
// -----------------------------------------------------------------------------
// peripheral_bfm_slave_axi4
//
// Downstream AXI4 slave memory model. Accepts AW/W/AR traffic from the
// peripheral BFM master and serves it from a word-addressed 32-bit memory of
// 2^MEM_AW words mapped at byte address BASE_ADDR. FIXED, INCR and WRAP bursts
// of 1-16 beats are supported; one outstanding transaction per direction, and
// the read and write channels run independently.
//
// Optional feature (compile-time macro PERIPHERAL_BFM_SLAVE_DECERR_EN):
//   defined   - beats addressed outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_AW)
//               are dropped on writes (burst bresp = DECERR) and return
//               rdata = 0 / rresp = DECERR on reads.
//   undefined - addresses alias modulo the memory depth; DECERR never occurs.
//
// Ports:
//   aclk, areset                          clock, synchronous active-high reset
//   awid/awadr/awlen/awsize/awburst       write address channel (awvalid/awready)
//   wid/wrdata/wstrb/wlast                write data channel (wvalid/wready);
//                                         wid is ignored, awid is authoritative
//   bid/bresp                             write response (bvalid/bready)
//   arid/araddr/arlen/arsize/arburst      read address channel (arvalid/arready)
//   rid/rdata/rresp/rlast                 read data channel (rvalid/rready)
// -----------------------------------------------------------------------------
module peripheral_bfm_slave_axi4 #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int DEPTH = 1 << MEM_AW;

`ifdef PERIPHERAL_BFM_SLAVE_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    // ------------------------------------------------------------------
    // Address helpers shared by both channels
    // ------------------------------------------------------------------

    // Word index relative to the window base; upper offset bits are dropped,
    // so indices wrap at the end of the memory.
    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off      = addr - BASE_ADDR;
        word_idx = off[MEM_AW+1:2];
    endfunction

    // Addresses below BASE_ADDR underflow to a huge offset and fall outside.
    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] off;
        off       = addr - BASE_ADDR;
        in_window = ((off >> (MEM_AW + 2)) == 32'd0);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [3:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [1:0]  sz;
        logic [31:0] step;
        logic [31:0] mask;
        logic        wrap_len;
        // The data bus is 32 bits wide, so anything wider than a word
        // steps by one word.
        sz       = (size > 3'd2) ? 2'd2 : size[1:0];
        step     = 32'd1 << sz;
        mask     = (({28'd0, len} + 32'd1) << sz) - 32'd1;
        wrap_len = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if ((burst == BURST_WRAP) && wrap_len)
            next_addr = (addr & ~mask) | ((addr + step) & mask);
        else
            next_addr = addr + step;
    endfunction

    // ------------------------------------------------------------------
    // Memory
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    logic        mem_we;
    logic [31:0] aw_addr_q;

    // NOTE: the memory array has no reset branch; contents survive areset and
    // the array stays mappable onto RAM rather than a huge flop bank.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[word_idx(aw_addr_q)][8*b +: 8] <= wrdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0] w_state;
    logic [3:0] aw_len_q;
    logic [2:0] aw_size_q;
    logic [1:0] aw_burst_q;
    logic [3:0] w_cnt;
    logic       w_slverr;
    logic       w_decerr;

    logic w_beat;
    logic w_last_beat;
    logic w_beat_err;
    logic w_beat_oor;

    assign w_beat      = (w_state == W_DATA) && wvalid && wready;
    assign w_last_beat = (w_cnt == aw_len_q);
    // Termination follows the beat count; a disagreeing wlast only flags SLVERR.
    assign w_beat_err  = (wlast != w_last_beat);
    assign w_beat_oor  = DECERR_EN && !in_window(aw_addr_q);
    // A beat presented during reset is part of the aborted burst and is lost.
    assign mem_we      = w_beat && !areset && !w_beat_oor;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state    <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= 4'd0;
            bresp      <= RESP_OKAY;
            aw_addr_q  <= 32'd0;
            aw_len_q   <= 4'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_cnt      <= 4'd0;
            w_slverr   <= 1'b0;
            w_decerr   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        bid        <= awid;
                        aw_addr_q  <= awadr;
                        aw_len_q   <= awlen;
                        aw_size_q  <= awsize;
                        aw_burst_q <= awburst;
                        w_cnt      <= 4'd0;
                        w_slverr   <= 1'b0;
                        w_decerr   <= 1'b0;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                        w_cnt     <= w_cnt + 4'd1;
                        w_slverr  <= w_slverr | w_beat_err;
                        w_decerr  <= w_decerr | w_beat_oor;
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            // DECERR outranks SLVERR.
                            if (w_decerr || w_beat_oor)
                                bresp <= RESP_DECERR;
                            else if (w_slverr || w_beat_err)
                                bresp <= RESP_SLVERR;
                            else
                                bresp <= RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic        r_state;
    logic [31:0] ar_addr_q;
    logic [3:0]  ar_len_q;
    logic [2:0]  ar_size_q;
    logic [1:0]  ar_burst_q;
    logic [3:0]  r_cnt;

    logic        r_load;
    logic [31:0] r_fetch_addr;
    logic        r_oor;

    // Address of the word to register into rdata this cycle: the AR address
    // on acceptance, or the next burst address when the current beat retires.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        r_load       = 1'b0;
        r_fetch_addr = ar_addr_q;
        if ((r_state == R_IDLE) && arvalid && arready) begin
            r_load       = 1'b1;
            r_fetch_addr = araddr;
        end else if ((r_state == R_DATA) && rvalid && rready && !rlast) begin
            r_load       = 1'b1;
            r_fetch_addr = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
        end
    end

    assign r_oor = DECERR_EN && !in_window(r_fetch_addr);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rid        <= 4'd0;
            rdata      <= 32'd0;
            rresp      <= RESP_OKAY;
            ar_addr_q  <= 32'd0;
            ar_len_q   <= 4'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready    <= 1'b0;
                        rid        <= arid;
                        ar_len_q   <= arlen;
                        ar_size_q  <= arsize;
                        ar_burst_q <= arburst;
                        r_cnt      <= 4'd0;
                        rvalid     <= 1'b1;
                        rlast      <= (arlen == 4'd0);
                        r_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    // Without a handshake nothing changes, so the beat holds.
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            rlast <= ((r_cnt + 4'd1) == ar_len_q);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            // Registered read: a same-cycle write to this word is not seen.
            if (r_load) begin
                ar_addr_q <= r_fetch_addr;
                rdata     <= r_oor ? 32'd0 : mem[word_idx(r_fetch_addr)];
                rresp     <= r_oor ? RESP_DECERR : RESP_OKAY;
            end
        end
    end

    // The write ID on the data channel carries no information for this model.
    logic unused_wid;
    assign unused_wid = ^wid;

endmodule

// File: tb/tb_peripheral_bfm_slave_axi4.sv
// -----------------------------------------------------------------------------
// tb_peripheral_bfm_slave_axi4
//
// Directed bench for peripheral_bfm_slave_axi4 (MEM_AW=10, BASE_ADDR=0).
// Driver tasks push the expected B and R responses into queues as they issue
// each transaction; independent monitors pop and compare whenever bvalid or
// rvalid is presented. Honours PERIPHERAL_BFM_SLAVE_DECERR_EN like the RTL.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_peripheral_bfm_slave_axi4;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awadr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wrdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    peripheral_bfm_slave_axi4 #(.MEM_AW(10), .BASE_ADDR(32'h0000_0000)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] rexp [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge aclk) begin
        if (!areset && bvalid) begin
            if (b_q.size() == 0) begin
                check("b_unexpected", 32'd1, 32'd0);
            end else begin
                check("bid", 32'(bid), 32'(b_q[0].id));
                check("bresp", 32'(bresp), 32'(b_q[0].resp));
                if (bready) void'(b_q.pop_front());
            end
        end
    end

    // Compared on every valid cycle, so a stalled beat must also stay put.
    always @(negedge aclk) begin
        if (!areset && rvalid) begin
            if (r_q.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                check("rdata", rdata, r_q[0].data);
                check("rid", 32'(rid), 32'(r_q[0].id));
                check("rresp", 32'(rresp), 32'(r_q[0].resp));
                check("rlast", 32'(rlast), 32'(r_q[0].last));
                if (rready) void'(r_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Waits (bounded) for the ready of channel ch with its valid already up.
    task automatic hs_wait(input int ch, input string name);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge aclk);
            case (ch)
                0:       hs = awready;
                1:       hs = wready;
                default: hs = arready;
            endcase
            @(posedge aclk);
            #1;
            n++;
        end
        if (!hs) check(name, 32'd0, 32'd1);
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst);
        @(posedge aclk);
        #1;
        awid = id; awadr = addr; awlen = len; awsize = 3'd2; awburst = burst;
        awvalid = 1'b1;
        hs_wait(0, "aw_timeout");
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        wrdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        hs_wait(1, "w_timeout");
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [1:0] burst,
                               input logic [15:0] lastm, input logic [1:0] exp_resp);
        int n;
        b_q.push_back('{id: id, resp: exp_resp});
        aw_phase(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) w_beat(wdat[i], wstb[i], lastm[i]);
        @(negedge aclk);
        check("b_latency", 32'(bvalid), 32'd1);
        n = 0;
        while (bvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic write1(input logic [3:0] id, input logic [31:0] addr,
                          input logic [31:0] d, input logic [1:0] exp_resp);
        wdat[0] = d;
        write_burst(id, addr, 4'd0, INCR, 16'h0001, exp_resp);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst,
                              input logic toggle, input logic [1:0] exp_resp);
        int beats;
        int k;
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back('{id: id, data: rexp[i], resp: exp_resp, last: (i == int'(len))});
        @(posedge aclk);
        #1;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1;
        hs_wait(2, "ar_timeout");
        arvalid = 1'b0;
        beats = 0;
        k     = 0;
        while (beats <= int'(len) && k < 100) begin
            rready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge aclk);
            if (k == 0) check("r_latency", 32'(rvalid), 32'd1);
            if (rvalid && rready) beats++;
            k++;
            @(posedge aclk);
            #1;
        end
        rready = 1'b1;
        if (beats <= int'(len)) check("r_timeout", 32'(beats), 32'(len) + 32'd1);
    endtask

    task automatic set_w(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        wdat[0] = a; wdat[1] = b; wdat[2] = c; wdat[3] = d;
    endtask

    task automatic set_r(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        rexp[0] = a; rexp[1] = b; rexp[2] = c; rexp[3] = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        areset = 1'b1;
        awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        bready = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
        rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'd0;
            wstb[i] = 4'hF;
            rexp[i] = 32'd0;
        end

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // Single write / read
        write1(4'd3, 32'h10, 32'hDEAD_BEEF, 2'b00);
        rexp[0] = 32'hDEAD_BEEF;
        read_burst(4'd5, 32'h10, 4'd0, INCR, 1'b0, 2'b00);

        // INCR 4-beat write, read back with rready toggling
        set_w(32'd1, 32'd2, 32'd3, 32'd4);
        write_burst(4'd1, 32'h20, 4'd3, INCR, 16'h0008, 2'b00);
        set_r(32'd1, 32'd2, 32'd3, 32'd4);
        read_burst(4'd2, 32'h20, 4'd3, INCR, 1'b1, 2'b00);

        // WRAP len 3 from 0x38: A->0x38, B->0x3C, C->0x30, D->0x34
        set_w(32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D);
        write_burst(4'd4, 32'h38, 4'd3, WRAP, 16'h0008, 2'b00);
        set_r(32'hCCCC_000C, 32'hDDDD_000D, 32'hAAAA_000A, 32'hBBBB_000B);
        read_burst(4'd6, 32'h30, 4'd3, INCR, 1'b0, 2'b00);
        set_r(32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D);
        read_burst(4'd7, 32'h38, 4'd3, WRAP, 1'b0, 2'b00);

        // Byte strobes
        write1(4'd8, 32'h40, 32'hFFFF_FFFF, 2'b00);
        wstb[0] = 4'b0101;
        write1(4'd9, 32'h40, 32'h1122_3344, 2'b00);
        wstb[0] = 4'hF;
        rexp[0] = 32'hFF22_FF44;
        read_burst(4'd10, 32'h40, 4'd0, INCR, 1'b0, 2'b00);

        // FIXED burst keeps hitting the same word; the last beat wins
        set_w(32'd5, 32'd6, 32'd7, 32'd8);
        write_burst(4'd11, 32'h44, 4'd3, FIXED, 16'h0008, 2'b00);
        rexp[0] = 32'd8;
        read_burst(4'd12, 32'h44, 4'd0, INCR, 1'b0, 2'b00);

        // Early wlast on beat 1 of a 3-beat burst: all 3 beats land, SLVERR
        set_w(32'h21, 32'h22, 32'h23, 32'h0);
        write_burst(4'd13, 32'h50, 4'd2, INCR, 16'h0006, 2'b10);
        set_r(32'h21, 32'h22, 32'h23, 32'h0);
        read_burst(4'd14, 32'h50, 4'd2, INCR, 1'b0, 2'b00);

        // Reset mid-burst: two beats written, third beat presented under reset
        write1(4'd15, 32'h88, 32'hCAFE_F00D, 2'b00);
        aw_phase(4'd7, 32'h80, 4'd3, INCR);
        w_beat(32'h111, 4'hF, 1'b0);
        w_beat(32'h222, 4'hF, 1'b0);
        wrdata = 32'h333; wstrb = 4'hF; wvalid = 1'b1; areset = 1'b1;
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
        @(negedge aclk);
        check("midrst_awready", 32'(awready), 32'd0);
        check("midrst_wready", 32'(wready), 32'd0);
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_bvalid", 32'(bvalid), 32'd0);
        set_r(32'h111, 32'h222, 32'hCAFE_F00D, 32'h0);
        read_burst(4'd8, 32'h80, 4'd2, INCR, 1'b0, 2'b00);

        // Out-of-window access at 0x1000
        write1(4'd1, 32'h0, 32'h0BAD_0000, 2'b00);
`ifdef PERIPHERAL_BFM_SLAVE_DECERR_EN
        write1(4'd2, 32'h1000, 32'h0000_0055, 2'b11);
        rexp[0] = 32'h0BAD_0000;
        read_burst(4'd3, 32'h0, 4'd0, INCR, 1'b0, 2'b00);
        rexp[0] = 32'h0;
        read_burst(4'd4, 32'h1000, 4'd0, INCR, 1'b0, 2'b11);
`else
        write1(4'd2, 32'h1000, 32'h0000_0055, 2'b00);
        rexp[0] = 32'h0000_0055;
        read_burst(4'd3, 32'h0, 4'd0, INCR, 1'b0, 2'b00);
`endif

        // Drain and confirm every expected response was observed
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
